fxp_mult_arbiter: RTL

Round-robin arbiter that shares one `fixed_point_iterative_Multiplier` instance among `NREQ` independent requesters. Each requester has its own val/rdy request and response channels. The arbiter grants the unpipelined multiplier to one requester at a time, forwards that requester's operands, and routes the product back to the same requester. It sits between compute clients (filters, controllers) and the single shared multiplier, which it connects to through the multiplier's recv/send ports.

---
 rtl/fxp_mult_arb_pkg.sv | 5 +
 rtl/rr_priority_picker.sv | 22 ++
 rtl/fxp_mult_arbiter.sv | 62 ++++++
 3 files changed

// File: rtl/fxp_mult_arb_pkg.sv
// fxp_mult_arb_pkg: shared types and constants for the multiplier arbiter
package fxp_mult_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int OPS_W = 16;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first valid index at or after ptr, wrapping modulo NREQ
module rr_priority_picker #(
  parameter int NREQ = 4,
  localparam int W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] val,
  input  logic [W-1:0]    ptr,
  output logic            any,
  output logic [W-1:0]    g
);
  logic [W-1:0] idx;
  assign any = |val;
  // scan from the farthest slot back toward ptr so the nearest valid slot wins
  always_comb begin
    g = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % NREQ);
      g = val[idx] ? idx : g;
    end
  end
endmodule

// File: rtl/fxp_mult_arbiter.sv
// fxp_mult_arbiter: round-robin sharing of one iterative multiplier among NREQ requesters
module fxp_mult_arbiter
  import fxp_mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int n = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  output logic [NREQ-1:0]   resp_val,
  input  logic [NREQ-1:0]   resp_rdy,
  output logic [n-1:0]      resp_c,
  output logic              mul_recv_val,
  input  logic              mul_recv_rdy,
  output logic [n-1:0]      mul_a,
  output logic [n-1:0]      mul_b,
  input  logic              mul_send_val,
  output logic              mul_send_rdy,
  input  logic [n-1:0]      mul_c,
  output logic [OPS_W-1:0]  ops_done
);
  localparam int W = $clog2(NREQ);
  state_t state, state_nx;
  logic [W-1:0] owner, ptr, g;
  logic any, acc, fire;
  rr_priority_picker #(.NREQ(NREQ)) picker (.val(req_val), .ptr(ptr), .any(any), .g(g));
  assign acc = state == IDLE && any && mul_recv_rdy;
  assign fire = state == BUSY && mul_send_val && resp_rdy[owner];
  assign resp_c = mul_c;
  // operand mux toward the multiplier while idle, result demux toward the owner while busy
  always_comb begin
    state_nx = acc ? BUSY : fire ? IDLE : state;
    req_rdy = '0;
    resp_val = '0;
    req_rdy[g] = acc;
    resp_val[owner] = state == BUSY && mul_send_val;
    mul_recv_val = state == IDLE && any;
    mul_a = mul_recv_val ? req_a[int'(g)*n +: n] : '0;
    mul_b = mul_recv_val ? req_b[int'(g)*n +: n] : '0;
    mul_send_rdy = state == BUSY && resp_rdy[owner];
  end
  // state, grant bookkeeping and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        owner <= g;
        ptr <= (int'(g) == NREQ - 1) ? '0 : g + W'(1);
      end
      if (fire) ops_done <= ops_done + OPS_W'(1);
    end
  end
endmodule
